// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem request engine and IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating perf_bubbles/perf_drops counters.
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect_d,
    input  logic [PC_W-1:0] redirect_pc_d,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_d,
    output logic [PC_W-1:0] pc_d,
    output logic [PC_W-1:0] pc_plus4_d,
    output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_drops
`endif
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
    logic            r_drop, w_drop_nxt;
    logic [31:0]     r_buf, w_load_instr;
    logic            w_redir, w_load, w_take, w_capture, w_discard;
    assign w_redir   = redirect_d && !stall_d;
    assign w_pc_inc  = r_pc + PC_W'(4);
    assign imem_addr = r_pc;
    assign w_take    = w_load && !flush_d;
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_drop_nxt   = r_drop;
        w_load       = 1'b0;
        w_load_instr = imem_rdata;
        w_capture    = 1'b0;
        w_discard    = 1'b0;
        imem_req     = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = rst_n && !stall_f && !w_redir;
                if (w_redir) w_pc_nxt = redirect_pc_d;
                else if (imem_req && imem_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_FETCH;
                    if (r_drop || w_redir) begin
                        w_discard  = 1'b1;
                        w_drop_nxt = 1'b0;
                        if (w_redir) w_pc_nxt = redirect_pc_d;
                    end else if (stall_d) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc_inc;
                    end
                end else if (w_redir) begin
                    // response still in flight: remember to throw it away
                    w_pc_nxt   = redirect_pc_d;
                    w_drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                w_load_instr = r_buf;
                if (w_redir) begin
                    w_discard   = 1'b1;
                    w_pc_nxt    = redirect_pc_d;
                    w_state_nxt = S_FETCH;
                end else if (!stall_d) begin
                    w_load      = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_capture) r_buf <= imem_rdata;
        end
    end
    // bubbles keep the last pc_d/pc_plus4_d; only a real load moves them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d    <= '0;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall_d) begin
            valid_d <= w_take;
            instr_d <= w_take ? w_load_instr : 32'h0;
            if (w_take) begin
                pc_d       <= r_pc;
                pc_plus4_d <= w_pc_inc;
            end
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles <= '0;
            perf_drops   <= '0;
        end else begin
            if (!stall_d && !w_take && perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
            if (w_discard && perf_drops != 32'hFFFF_FFFF) perf_drops <= perf_drops + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, async reset sequence, then randomized run vs. transaction model.
module tb_fetch_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall_f, stall_d, flush_d, redirect_d, imem_ready, imem_rvalid;
    logic [31:0] redirect_pc_d, imem_rdata;
    logic        imem_req, valid_d;
    logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .redirect_d(redirect_d), .redirect_pc_d(redirect_pc_d), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d)
    );

    typedef struct {
        logic        sf, sd, fl, rd;
        logic [31:0] rpc;
        logic        rdy, rv;
        logic [31:0] rdat;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] ei, ep, ep4;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic sf, sd, fl, rd, input logic [31:0] rpc,
                                input logic rdy, rv, input logic [31:0] rdat,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] ei, ep, ep4);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fl = fl; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rv = rv;
        v.rdat = rdat; v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.ei = ei; v.ep = ep; v.ep4 = ep4;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic sf, sd, fl, rd, input logic [31:0] rpc,
                         input logic rdy, rv, input logic [31:0] rdat);
        stall_f = sf; stall_d = sd; flush_d = fl; redirect_d = rd; redirect_pc_d = rpc;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdat;
    endtask

    // transaction-level reference model state
    logic [31:0] m_pc, m_hbuf, m_instr, m_pcd, m_p4, ldi, rpc, rdat;
    logic        m_out, m_doom, m_held, m_v, sf, sd, rd, rdy, rv, redir, ereq, ld;
    int          lat;

    initial begin
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset req", imem_req, 0);
        chk("reset addr", imem_addr, 0);
        chk("reset valid_d", valid_d, 0);
        chk("reset instr_d", instr_d, 0);
        chk("reset pc_d", pc_d, 0);
        chk("reset pc_plus4_d", pc_plus4_d, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        //            sf sd fl rd rpc           rdy rv rdat            req addr          v  instr           pc            pc+4
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 0,            0, 0,            0,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h2008_0005, 0, 0,           1, 32'h2008_0005, 0,           4));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 4,            0, 0,            0,            4));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'hA000_000A, 0, 4,           1, 32'hA000_000A, 4,           8));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 8,            0, 0,            4,            8));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0, 0, 0,            0, 8,            0, 0,            4,            8));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0, 1, 32'hB000_000B, 0, 8,           0, 0,            4,            8));
        tbl.push_back(mk(0, 1, 0, 0, 0,            1, 0, 0,            0, 8,            0, 0,            4,            8));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            0, 8,            1, 32'hB000_000B, 8,           12));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 12,           0, 0,            8,            12));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'hC000_000C, 0, 12,          1, 32'hC000_000C, 12,          16));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 16,           0, 0,            12,           16));
        tbl.push_back(mk(0, 0, 1, 1, 32'h40,       0, 0, 0,            0, 16,           0, 0,            12,           16));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'hD000_000D, 0, 32'h40,      0, 0,            12,           16));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 32'h40,       0, 0,            12,           16));
        tbl.push_back(mk(0, 0, 1, 1, 32'h80,       0, 1, 32'hE000_000E, 0, 32'h40,      0, 0,            12,           16));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,            1, 32'h80,       0, 0,            12,           16));
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 0, 0,            0, 32'h80,       0, 0,            12,           16));
        tbl.push_back(mk(1, 0, 0, 0, 0,            1, 0, 0,            0, 32'h80,       0, 0,            12,           16));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 32'h80,       0, 0,            12,           16));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'hF000_000F, 0, 32'h80,      1, 32'hF000_000F, 32'h80,     32'h84));
        tbl.push_back(mk(0, 1, 1, 1, 32'h200,      1, 0, 0,            1, 32'h84,       1, 32'hF000_000F, 32'h80,     32'h84));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h1111_0001, 0, 32'h84,      1, 32'h1111_0001, 32'h84,     32'h88));
        tbl.push_back(mk(0, 0, 1, 1, 32'h100,      1, 0, 0,            0, 32'h88,       0, 0,            32'h84,       32'h88));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 32'h100,      0, 0,            32'h84,       32'h88));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h2222_0002, 0, 32'h100,     1, 32'h2222_0002, 32'h100,    32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 32'h104,      0, 0,            32'h100,      32'h104));
        tbl.push_back(mk(0, 1, 0, 0, 0,            0, 1, 32'h3333_0003, 0, 32'h104,     0, 0,            32'h100,      32'h104));
        tbl.push_back(mk(0, 0, 1, 1, 32'h20,       0, 0, 0,            0, 32'h104,      0, 0,            32'h100,      32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 32'h20,       0, 0,            32'h100,      32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h4444_0004, 0, 32'h20,      1, 32'h4444_0004, 32'h20,     32'h24));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h5555_0005, 1, 32'h24,      0, 0,            32'h20,       32'h24));
        tbl.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0,           0, 32'h24,       0, 0,            32'h20,       32'h24));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,           32'h20,       32'h24));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h6666_0006, 0, 32'hFFFF_FFFC, 1, 32'h6666_0006, 32'hFFFF_FFFC, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,            1, 0,            0, 0,            32'hFFFF_FFFC, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,            1, 0,            0, 0,            32'hFFFF_FFFC, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].sf, tbl[i].sd, tbl[i].fl, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].rv, tbl[i].rdat);
            #4;
            chk($sformatf("row%0d imem_req", i), imem_req, tbl[i].ereq);
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].eaddr);
            @(posedge clk); #1;
            chk($sformatf("row%0d valid_d", i), valid_d, tbl[i].ev);
            chk($sformatf("row%0d instr_d", i), instr_d, tbl[i].ei);
            chk($sformatf("row%0d pc_d", i), pc_d, tbl[i].ep);
            chk($sformatf("row%0d pc_plus4_d", i), pc_plus4_d, tbl[i].ep4);
        end

        // async reset while a request is outstanding
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset valid_d", valid_d, 0);
        chk("midreset instr_d", instr_d, 0);
        chk("midreset pc_d", pc_d, 0);
        chk("midreset pc_plus4_d", pc_plus4_d, 0);
        chk("midreset req", imem_req, 0);
        @(posedge clk); #1;
        chk("inreset req", imem_req, 0);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        #4;
        chk("late rvalid req", imem_req, 1);
        chk("late rvalid addr", imem_addr, 0);
        @(posedge clk); #1;
        chk("late rvalid valid_d", valid_d, 0);
        chk("late rvalid instr_d", instr_d, 0);

        m_pc = 0; m_out = 0; m_doom = 0; m_held = 0; m_hbuf = 0;
        m_v = 0; m_instr = 0; m_pcd = 0; m_p4 = 0; lat = 0;
        for (int n = 0; n < 3000; n++) begin
            sf   = $urandom_range(0, 3) == 0;
            sd   = $urandom_range(0, 3) == 0;
            rd   = $urandom_range(0, 6) == 0;
            rpc  = 32'($urandom_range(0, 1023)) << 2;
            rdy  = $urandom_range(0, 2) != 0;
            rdat = $urandom;
            rv   = m_out ? (lat == 0) : (!m_held && $urandom_range(0, 7) == 0);
            redir = rd && !sd;
            ereq  = !m_out && !m_held && !sf && !redir;
            apply(sf, sd, rd, rd, rpc, rdy, rv, rdat);
            #4;
            chk("rnd imem_req", imem_req, ereq);
            chk("rnd imem_addr", imem_addr, m_pc);
            ld = 0; ldi = 0;
            if (m_out && rv) begin
                m_out = 0;
                if (m_doom || redir) m_doom = 0;
                else if (sd) begin m_held = 1; m_hbuf = rdat; end
                else begin ld = 1; ldi = rdat; end
            end else if (m_held) begin
                if (redir) m_held = 0;
                else if (!sd) begin ld = 1; ldi = m_hbuf; m_held = 0; end
            end else if (m_out && redir) m_doom = 1;
            if (ereq && rdy) begin m_out = 1; lat = $urandom_range(0, 3); end
            else if (m_out) lat--;
            if (!sd) begin
                if (!rd && ld) begin m_v = 1; m_instr = ldi; m_pcd = m_pc; m_p4 = m_pc + 4; end
                else begin m_v = 0; m_instr = 0; end
            end
            if (redir) m_pc = rpc;
            else if (ld) m_pc = m_pc + 4;
            @(posedge clk); #1;
            chk("rnd valid_d", valid_d, m_v);
            chk("rnd instr_d", instr_d, m_instr);
            chk("rnd pc_d", pc_d, m_pcd);
            chk("rnd pc_plus4_d", pc_plus4_d, m_p4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline front end: PC register, single-outstanding instruction-memory request engine, and IF/ID pipeline register.
- Consumes the hazard unit's stall_f, stall_d and flush_d, plus the decode-stage redirect (branch/jump target).
- Tolerates variable instruction-memory latency by inserting bubbles into decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
PC_W, 32, PC/address width; low 2 bits always zero.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall_f  input  1  hazard unit: freeze PC and block new request issue
stall_d  input  1  hazard unit: hold IF/ID contents
flush_d  input  1  hazard unit: load bubble into IF/ID
redirect_d  input  1  decode: taken branch or jump this cycle
redirect_pc_d  input  PC_W  decode: target address
imem_req  output  1  request valid
imem_addr  output  PC_W  request address (= pc_f)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid
imem_rdata  input  32  response instruction word
instr_d  output  32  IF/ID instruction (32'h0 = NOP on bubble)
pc_d  output  PC_W  IF/ID PC
pc_plus4_d  output  PC_W  IF/ID PC+4
valid_d  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0): pc_f=RESET_PC, state=FETCH, drop=0, hold buffer empty; instr_d=0, pc_d=0, pc_plus4_d=0, valid_d=0; imem_req=0 while rst_n=0.
- Effective redirect: redir = redirect_d && !stall_d. Redirect while stall_d=1 is ignored.
- States:
  - FETCH: imem_req = !stall_f && !redir. On imem_req && imem_ready -> WAIT. On redir: pc_f<=redirect_pc_d, stay FETCH. imem_rvalid ignored in FETCH.
  - WAIT: imem_req=0.
    - imem_rvalid with (drop || redir): discard response, drop<=0, -> FETCH.
    - imem_rvalid, no drop, !stall_d: load IF/ID {imem_rdata, pc_f, pc_f+4, valid=1}, pc_f<=pc_f+4, -> FETCH.
    - imem_rvalid, no drop, stall_d: capture {rdata, pc_f} in hold buffer -> HOLD.
    - redir without rvalid: pc_f<=redirect_pc_d, drop<=1, stay WAIT.
  - HOLD: imem_req=0.
    - !stall_d and !redir: load IF/ID from buffer, pc_f<=pc_f+4, -> FETCH.
    - redir: discard buffer, pc_f<=redirect_pc_d, -> FETCH.
- PC increment wraps modulo 2^PC_W.
- IF/ID update priority:
  - stall_d=1: hold all fields.
  - flush_d=1: bubble (instr_d=0, valid_d=0; pc_d and pc_plus4_d hold).
  - New instruction available this cycle: load it.
  - Otherwise: bubble.
- flush_d with a same-cycle response load: flush wins and the response is discarded (redir is asserted alongside flush_d).
- Latency: minimum 2 cycles from request acceptance to valid_d, when memory responds the cycle after acceptance. Sustained throughput is 1 instruction per 2 cycles (single outstanding request).
- stall_f=1 in FETCH suppresses issue only; stall_f has no effect in WAIT or HOLD.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_bubbles[31:0] (increments on each cycle IF/ID loads a bubble while stall_d=0) and perf_drops[31:0] (increments on each discarded response or hold buffer). Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, imem_ready=1, rvalid 1 cycle after accept, rdata=32'h2008_0005 -> first imem_addr=0; valid_d=1, instr_d=32'h2008_0005, pc_d=0, pc_plus4_d=4 on cycle 2; next imem_addr=4.
- Accept at pc 8, stall_d=1 for 3 cycles, rvalid during stall -> HOLD; IF/ID unchanged; instruction at pc_d=8 appears the cycle after stall_d drops; no re-request of 8.
- Accept at pc 0x10, redirect_d=1 with redirect_pc_d=0x40 before rvalid -> response discarded; next imem_addr=0x40; valid_d=0 meanwhile.
- Same cycle: imem_rvalid and redirect_d=1, flush_d=1, target 0x80 -> valid_d=0, instr_d=0; next request addr 0x80.
- stall_f=1 in FETCH for 2 cycles -> imem_req=0; issue resumes at unchanged pc_f. rst_n pulsed low mid-WAIT -> outputs zero immediately; late rvalid ignored; next request at RESET_PC.
- With FETCH_PERF_CNT_EN: the redirect scenario yields perf_drops=1; a 3-cycle memory latency yields perf_bubbles incrementing by 2 per instruction.
